// File: rtl/rori_arb.sv
// Two-port round-robin scheduler in front of one shared packed rotate-right-immediate
// unit, with a registered 1-entry response slot per port and a handoff counter.
module rori_arb #(
  parameter int CNT_W     = 16,
  parameter int RESET_PRI = 0
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [4:0]       req0_imm,
  input  logic [31:0]      req0_rs1,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_rd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [4:0]       req1_imm,
  input  logic [31:0]      req1_rs1,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_rd,
  output logic [CNT_W-1:0] ops_done
);

  // Each lane rotates by imm masked to the lane width; upper imm bits simply drop out.
  function automatic logic [31:0] rori_lanes(input logic [1:0] op, input logic [4:0] imm,
                                             input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    case (op)
      2'b00: for (int i = 0; i < 8; i++)
        r[4*i +: 4] = (x[4*i +: 4] >> imm[1:0]) | (x[4*i +: 4] << (3'd4 - {1'b0, imm[1:0]}));
      2'b01: for (int i = 0; i < 4; i++)
        r[8*i +: 8] = (x[8*i +: 8] >> imm[2:0]) | (x[8*i +: 8] << (4'd8 - {1'b0, imm[2:0]}));
      2'b10: for (int i = 0; i < 2; i++)
        r[16*i +: 16] = (x[16*i +: 16] >> imm[3:0]) | (x[16*i +: 16] << (5'd16 - {1'b0, imm[3:0]}));
      default: r = (x >> imm) | (x << (6'd32 - {1'b0, imm}));
    endcase
    return r;
  endfunction

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp0_rd_q, rsp0_rd_d;
  logic [31:0]      rsp1_rd_q, rsp1_rd_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic        hs0, hs1, elig0, elig1, grant0, grant1;
  logic [1:0]  sel_op;
  logic [4:0]  sel_imm;
  logic [31:0] sel_rs1, rot_res;

  always_comb begin
    hs0   = rsp0_valid_q & rsp0_ready;
    hs1   = rsp1_valid_q & rsp1_ready;
    // A slot draining this cycle can be refilled in the same cycle.
    elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);
    grant0 = elig0 & (~elig1 | ~ptr_q);
    grant1 = elig1 & (~elig0 | ptr_q);

    sel_op  = grant1 ? req1_op  : req0_op;
    sel_imm = grant1 ? req1_imm : req0_imm;
    sel_rs1 = grant1 ? req1_rs1 : req0_rs1;
    rot_res = rori_lanes(sel_op, sel_imm, sel_rs1);

    rsp0_valid_d = grant0 | (rsp0_valid_q & ~rsp0_ready);
    rsp1_valid_d = grant1 | (rsp1_valid_q & ~rsp1_ready);
    rsp0_rd_d    = grant0 ? rot_res : rsp0_rd_q;
    rsp1_rd_d    = grant1 ? rot_res : rsp1_rd_q;

    ptr_d = ptr_q;
    if (grant0)      ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;

    ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, hs0} + {{(CNT_W-1){1'b0}}, hs1};
  end

  // Response slot / pointer / counter register stage
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rd_q    <= '0;
      rsp1_rd_q    <= '0;
      ptr_q        <= (RESET_PRI != 0);
      ops_done_q   <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rd_q    <= rsp0_rd_d;
      rsp1_rd_q    <= rsp1_rd_d;
      ptr_q        <= ptr_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rd    = rsp0_rd_q;
  assign rsp1_rd    = rsp1_rd_q;
  assign ops_done   = ops_done_q;

endmodule

// File: doc/rori_arb.md
Name: rori_arb

Overview:
- Shared-resource scheduler for the packed rotate-right-immediate datapath. The datapath supports nibble, byte, halfword and word lanes (rori.n/b/h/w).
- Two requesters share one rotate unit: port 0 is the core ISE issue path and port 1 is the GIFT-COFB key-schedule/permutation helper.
- Provides valid/ready request and response handshakes, round-robin arbitration, a registered 1-entry response buffer per port, and a completed-op counter.

Parameters:
- CNT_W, 16, width of completed-operation counter.
- RESET_PRI, 0, requester holding priority after reset (0 or 1).

Ports:
- g_clk  in  1  clock; all state on rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  2  00=rori.n, 01=rori.b, 10=rori.h, 11=rori.w.
- req0_imm  in  5  rotate amount.
- req0_rs1  in  32  source operand.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 consumer accepts result.
- rsp0_rd  out  32  port 0 result.
- req1_valid, req1_ready, req1_op, req1_imm, req1_rs1  same as port 0, for port 1.
- rsp1_valid, rsp1_ready, rsp1_rd  same as port 0, for port 1.
- ops_done  out  CNT_W  count of results handed off (both ports).

Behaviour:
- Reset (async, g_resetn=0):
  - rsp0_valid=rsp1_valid=0; rsp0_rd=rsp1_rd=0; ops_done=0; priority pointer=RESET_PRI.
  - An in-flight request is dropped. Reset mid-handshake loses it; the requester must reissue.
- Rotate function: rotate right within each lane; all lanes use the same amount.
  - Effective amount is imm masked to lane width: n uses imm[1:0], b uses imm[2:0], h uses imm[3:0], w uses imm[4:0].
  - Upper imm bits are ignored, never an error.
- Slot free: port i's slot is free when rspi_valid=0, or when rspi_valid=1 and rspi_ready=1 in the same cycle (same-cycle drain and refill allowed).
- Eligible: port i is eligible when reqi_valid=1 and its slot is free.
- Arbitration (combinational, one grant per cycle):
  - Only one eligible port: it is granted.
  - Both eligible: the port named by the priority pointer is granted.
  - reqi_ready = grant_i. It never asserts without reqi_valid.
  - reqi_ready does depend combinationally on reqi_valid and rspi_ready.
- Pointer update: after any grant, pointer := the other port. No grant leaves the pointer unchanged. A port that is eligible but loses is therefore granted on its next eligible cycle, so starvation is bounded at 1 cycle.
- Latency:
  - Grant at cycle t: the rotate of that port's operands is computed in cycle t and registered into its slot.
  - rspi_valid=1 and rspi_rd=result from cycle t+1.
  - Back-to-back throughput is 1 op/cycle total.
- Response hold: while rspi_valid=1 and rspi_ready=0, rspi_rd and rspi_valid stay stable and port i is not granted.
  - The other port continues to be served; head-of-line blocking is per port only.
- Response clear: rspi_ready=1 with no new grant clears rspi_valid next cycle. rspi_rd keeps its last value; it is don't-care when not valid.
- Counter:
  - ops_done increments by the number of response handoffs (rspi_valid&rspi_ready) per cycle: 0, 1 or 2.
  - Modulo 2^CNT_W: wraps from all-ones to 0 (or to 1 for a double handoff).
- Inputs: req operands are sampled only in the grant cycle. They may change freely when ready=0.

Test Plan:
- Single op, port 0: req0 op=11 imm=1 rs1=0x00000001 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp0_rd=0x80000000; ops_done=1 after handoff.
- Lane checks, port 1:
  - op=01 imm=1 rs1=0x01020304 -> 0x80018102.
  - op=00 imm=1 rs1=0x12345678 -> 0x8192A3B4.
  - op=10 imm=4 rs1=0x00010002 -> 0x10002000.
  - op=00 imm=5 rs1=0x12345678 -> 0x8192A3B4 (imm masked).
- Contention: both ports valid every cycle, rsp ready=1, RESET_PRI=0 -> grants alternate 0,1,0,1; each port gets 1 result every 2 cycles; ops_done increments by 1 per cycle.
- Backpressure: rsp0_ready=0 with rsp0 valid holding 0x80000000; port 0 and port 1 both requesting -> req0_ready=0, port 1 granted every cycle, rsp0_rd stable. Then rsp0_ready=1 -> same-cycle drain and refill of port 0 (no bubble).
- Counter wrap: CNT_W=4, 15 handoffs then a cycle with both ports handing off -> ops_done goes 15 -> 1.
- Async reset mid-op: assert g_resetn=0 between grant and response -> rsp0_valid=rsp1_valid=0 immediately (no clock edge), ops_done=0; after release, port RESET_PRI wins the first contended cycle.
